// File: rtl/add_accum32.sv
// Batch summer: accumulates a programmed number of 32-bit operands through the
// ripple adder and returns the modulo sum plus a sticky carry-out flag.

module adder32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic carry;

    always_comb begin
        sum   = '0;
        carry = cin;
        for (int unsigned i = 0; i < 32; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

module add_accum32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] rem_q, rem_d;

    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    adder32bit u_adder (
        .a    (acc_q),
        .b    (in_data),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    rem_d   = len;
                    state_d = (len != '0) ? ACCUM : HOLD;
                end
            end
            ACCUM: begin
                // in_ready is 1 throughout ACCUM, so in_valid alone marks a transfer
                if (in_valid) begin
                    acc_d = add_sum;
                    ovf_d = ovf_q | add_cout;
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            rem_q   <= rem_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign sum       = acc_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_add_accum32.sv
// Self-checking bench for add_accum32: directed table of batches, control
// corner cases, and random batches checked against an arithmetic reference.

module tb_add_accum32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        ovf;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] ops_mem [256];

    add_accum32 #(.WIDTH(32), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [31:0] ops [4];
        int          gap;
        int          stall;
        logic [31:0] exp_sum;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl [6];

    function automatic vec_t mk(input int n, input logic [31:0] o0, input logic [31:0] o1,
                                input logic [31:0] o2, input logic [31:0] o3,
                                input int gap, input int stall,
                                input logic [31:0] es, input logic eo);
        vec_t v;
        v.n = n;
        v.ops[0] = o0; v.ops[1] = o1; v.ops[2] = o2; v.ops[3] = o3;
        v.gap = gap; v.stall = stall; v.exp_sum = es; v.exp_ovf = eo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs one batch from ops_mem[0..n-1]; reference sum/carry kept with 64-bit arithmetic.
    task automatic run_batch(input int n, input int gap, input int stall,
                             output logic [31:0] got_sum, output logic got_ovf);
        longint unsigned ref_acc = 0;
        logic            ref_ovf = 1'b0;
        start = 1'b1;
        len   = 8'(n);
        tick();
        start = 1'b0;
        len   = 8'(($urandom_range(0, 255)));
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("in_ready_after_start", 32'(in_ready), 32'(n != 0));
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                tick();
                chk("hold_during_gap", sum, 32'(ref_acc));
                chk("in_ready_during_gap", 32'(in_ready), 32'd1);
            end
            in_valid = 1'b1;
            in_data  = ops_mem[i];
            tick();
            ref_acc = ref_acc + longint'(ops_mem[i]);
            if (ref_acc >= 64'h1_0000_0000) ref_ovf = 1'b1;
            ref_acc = ref_acc & 64'hFFFF_FFFF;
            chk("partial_sum", sum, 32'(ref_acc));
            chk("partial_ovf", 32'(ovf), 32'(ref_ovf));
            if (i < n - 1) chk("out_valid_early", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b0;
        chk("out_valid_at_result", 32'(out_valid), 32'd1);
        chk("in_ready_at_result", 32'(in_ready), 32'd0);
        chk("result_sum", sum, 32'(ref_acc));
        chk("result_ovf", 32'(ovf), 32'(ref_ovf));
        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = $urandom;
            tick();
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_sum", sum, 32'(ref_acc));
            chk("stall_ovf", 32'(ovf), 32'(ref_ovf));
        end
        in_valid = 1'b0;
        got_sum  = sum;
        got_ovf  = ovf;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("busy_after_handshake", 32'(busy), 32'd0);
        chk("out_valid_after_handshake", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] gs;
        logic        go;
        int          rn;

        rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #12;
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_sum", sum, 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        tbl[0] = mk(2, 32'd15, 32'd25, 0, 0, 0, 0, 32'd40, 1'b0);
        tbl[1] = mk(3, 32'hFFFF_FFFF, 32'd1, 32'd5, 0, 0, 0, 32'd5, 1'b1);
        tbl[2] = mk(0, 0, 0, 0, 0, 0, 0, 32'd0, 1'b0);
        tbl[3] = mk(4, 32'd100, 32'd200, 32'd1, 32'd1000, 2, 5, 32'd1301, 1'b0);
        tbl[4] = mk(1, 32'hFFFF_FFFF, 0, 0, 0, 0, 1, 32'hFFFF_FFFF, 1'b0);
        tbl[5] = mk(2, 32'h8000_0000, 32'h8000_0000, 0, 0, 1, 0, 32'd0, 1'b1);

        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < 4; k++) ops_mem[k] = tbl[t].ops[k];
            run_batch(tbl[t].n, tbl[t].gap, tbl[t].stall, gs, go);
            chk($sformatf("table%0d_sum", t), gs, tbl[t].exp_sum);
            chk($sformatf("table%0d_ovf", t), 32'(go), 32'(tbl[t].exp_ovf));
            tick();
        end

        // start pulsed mid-batch with a different len must not restart or resize it
        start = 1'b1; len = 8'd2;
        tick();
        start = 1'b1; len = 8'd9;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = 32'd1000000;
            tick();
        end
        in_valid = 1'b0;
        chk("midstart_out_valid", 32'(out_valid), 32'd1);
        chk("midstart_sum", sum, 32'd2000000);
        // start coincident with the result handshake is ignored
        start = 1'b1; len = 8'd3; out_ready = 1'b1;
        tick();
        start = 1'b0; out_ready = 1'b0;
        chk("hs_start_busy", 32'(busy), 32'd0);
        tick();
        chk("hs_start_busy_next", 32'(busy), 32'd0);
        chk("hs_start_in_ready", 32'(in_ready), 32'd0);

        // reset mid-batch
        start = 1'b1; len = 8'd3;
        tick();
        start = 1'b0; in_valid = 1'b1; in_data = 32'd7;
        tick();
        chk("pre_reset_sum", sum, 32'd7);
        in_data = 32'd11;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_sum", sum, 32'd0);
        chk("midrst_ovf", 32'(ovf), 32'd0);
        tick();
        rst_n = 1'b1; in_valid = 1'b0;
        tick();
        chk("post_reset_idle", 32'(busy), 32'd0);
        ops_mem[0] = 32'd9;
        run_batch(1, 0, 0, gs, go);
        chk("fresh_sum", gs, 32'd9);
        chk("fresh_ovf", 32'(go), 32'd0);

        // random batches, operands biased toward large values to exercise carry
        for (int r = 0; r < 20; r++) begin
            rn = $urandom_range(1, 12);
            for (int k = 0; k < rn; k++)
                ops_mem[k] = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 15)))
                                                         : ($urandom >> $urandom_range(0, 31));
            run_batch(rn, $urandom_range(0, 2), $urandom_range(0, 3), gs, go);
            if (($urandom_range(0, 1)) == 1) tick();
        end

        // maximum length: exactly 255 operands without counter wrap
        for (int k = 0; k < 255; k++) ops_mem[k] = $urandom;
        run_batch(255, 0, 1, gs, go);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, %0d miscompares so far", n_bad);
        $fatal(1);
    end

endmodule
